// File: rtl/reg_file_core.sv
// Memory-mapped register file: synchronous writes, combinational reads, invalid addresses ignored/read as zero.
// Optional access-error reporting (err, err_sticky) is built when REG_FILE_ERR_EN is defined.
module reg_file_core #(
  parameter int NUM_REGS = 4,
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic              re,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
`ifdef REG_FILE_ERR_EN
  output logic              err,
  output logic              err_sticky,
`endif
  output logic [DATA_W-1:0] rdata
);

  localparam int IDX_W = ADDR_W - 2;

  logic [DATA_W-1:0]   regs_r [NUM_REGS];
  logic [IDX_W:0]      index_s;
  logic                valid_s;
  logic [NUM_REGS-1:0] wsel_s;
  logic [DATA_W-1:0]   rdata_s;

  // Index is zero-extended by one bit so NUM_REGS == 2**IDX_W still compares correctly.
  assign index_s = {1'b0, addr[ADDR_W-1:2]};
  assign valid_s = (addr[1:0] == 2'b00) && (index_s < (IDX_W+1)'(NUM_REGS));

  // Address decode into one-hot write selects and the read mux.
  always_comb begin
    wsel_s  = {NUM_REGS{1'b0}};
    rdata_s = {DATA_W{1'b0}};
    for (int i = 0; i < NUM_REGS; i++) begin
      if (index_s == (IDX_W+1)'(i)) begin
        wsel_s[i] = we && valid_s;
        if (re && valid_s) begin
          rdata_s = regs_r[i];
        end else begin
          rdata_s = rdata_s;
        end
      end else begin
        wsel_s[i] = 1'b0;
      end
    end
  end

  assign rdata = rdata_s;

  // Register storage; reset wins over a same-edge write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_r[i] <= {DATA_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wsel_s[i]) begin
          regs_r[i] <= wdata;
        end
      end
    end
  end

`ifdef REG_FILE_ERR_EN
  logic err_s;
  logic err_sticky_r;

  assign err_s      = (we || re) && !valid_s;
  assign err        = err_s;
  assign err_sticky = err_sticky_r;

  // Sticky error flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_sticky_r <= 1'b0;
    end else if (err_s) begin
      err_sticky_r <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_reg_file_core.sv
// Directed self-checking bench for reg_file_core; covers error outputs when REG_FILE_ERR_EN is defined.
module tb_reg_file_core;

  logic        clk;
  logic        rst_n;
  logic        we;
  logic        re;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
`ifdef REG_FILE_ERR_EN
  logic        err;
  logic        err_sticky;
`endif

  int checks = 0;
  int errors = 0;

  reg_file_core #(.NUM_REGS(4), .DATA_W(32), .ADDR_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .we         (we),
    .re         (re),
    .addr       (addr),
    .wdata      (wdata),
`ifdef REG_FILE_ERR_EN
    .err        (err),
    .err_sticky (err_sticky),
`endif
    .rdata      (rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_word(input logic [7:0] a, input logic [31:0] d);
    we = 1'b1; re = 1'b0; addr = a; wdata = d;
    tick();
    we = 1'b0;
  endtask

  task automatic test_reset();
    logic [7:0] a;
    for (int i = 0; i < 4; i++) begin
      a = 8'(i * 4);
      re = 1'b1; we = 1'b0; addr = a; #1;
      checks++;
      if (rdata !== 32'h0) begin
        errors++;
        $display("FAIL reset_read addr=%h got=%h exp=%h", a, rdata, 32'h0);
      end
    end
`ifdef REG_FILE_ERR_EN
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_sticky got=%b exp=0", err_sticky);
    end
`endif
  endtask

  task automatic test_write_read();
    write_word(8'h00, 32'hDEADBEEF);
    re = 1'b1; addr = 8'h00; #1;
    checks++;
    if (rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_rd_00 got=%h exp=%h", rdata, 32'hDEADBEEF);
    end
    write_word(8'h0C, 32'h12345678);
    re = 1'b1; addr = 8'h0C; #1;
    checks++;
    if (rdata !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_rd_0c got=%h exp=%h", rdata, 32'h12345678);
    end
    addr = 8'h04; #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL untouched_04 got=%h exp=%h", rdata, 32'h0);
    end
  endtask

  task automatic test_invalid();
    logic [31:0] exp_tab [4];
    exp_tab[0] = 32'hDEADBEEF; exp_tab[1] = 32'h0;
    exp_tab[2] = 32'h0;        exp_tab[3] = 32'h12345678;
    we = 1'b1; re = 1'b0; addr = 8'h10; wdata = 32'hAAAAAAAA; #1;
`ifdef REG_FILE_ERR_EN
    checks++;
    if (err !== 1'b1) begin
      errors++;
      $display("FAIL err_invalid got=%b exp=1", err);
    end
`endif
    tick();
    we = 1'b0;
`ifdef REG_FILE_ERR_EN
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL sticky_set got=%b exp=1", err_sticky);
    end
`endif
    re = 1'b1; addr = 8'h10; #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL read_10 got=%h exp=%h", rdata, 32'h0);
    end
    addr = 8'hFC; #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL read_fc got=%h exp=%h", rdata, 32'h0);
    end
    for (int i = 0; i < 4; i++) begin
      addr = 8'(i * 4); #1;
      checks++;
      if (rdata !== exp_tab[i]) begin
        errors++;
        $display("FAIL after_invalid addr=%h got=%h exp=%h", addr, rdata, exp_tab[i]);
      end
    end
  endtask

  task automatic test_misaligned();
    write_word(8'h06, 32'h55555555);
    re = 1'b1; addr = 8'h06; #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL read_06 got=%h exp=%h", rdata, 32'h0);
    end
    addr = 8'h04; #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL misal_04 got=%h exp=%h", rdata, 32'h0);
    end
    addr = 8'h08; #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL misal_08 got=%h exp=%h", rdata, 32'h0);
    end
  endtask

  task automatic test_back_to_back();
    we = 1'b1; re = 1'b1; addr = 8'h08; wdata = 32'hCAFEF00D; #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL rw_old got=%h exp=%h", rdata, 32'h0);
    end
`ifdef REG_FILE_ERR_EN
    checks++;
    if (err !== 1'b0) begin
      errors++;
      $display("FAIL err_valid got=%b exp=0", err);
    end
`endif
    tick();
    we = 1'b0; #1;
    checks++;
    if (rdata !== 32'hCAFEF00D) begin
      errors++;
      $display("FAIL rw_new got=%h exp=%h", rdata, 32'hCAFEF00D);
    end
    re = 1'b0; #1;
    checks++;
    if (rdata !== 32'h0) begin
      errors++;
      $display("FAIL re_low got=%h exp=%h", rdata, 32'h0);
    end
  endtask

  task automatic test_reset_priority();
    rst_n = 1'b0; we = 1'b1; re = 1'b0; addr = 8'h04; wdata = 32'h00000001;
    tick();
    rst_n = 1'b1; we = 1'b0; re = 1'b1;
    for (int i = 0; i < 4; i++) begin
      addr = 8'(i * 4); #1;
      checks++;
      if (rdata !== 32'h0) begin
        errors++;
        $display("FAIL rst_prio addr=%h got=%h exp=%h", addr, rdata, 32'h0);
      end
    end
`ifdef REG_FILE_ERR_EN
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL sticky_clr got=%b exp=0", err_sticky);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0; we = 1'b0; re = 1'b0; addr = 8'h00; wdata = 32'h0;
    tick();
    tick();
    rst_n = 1'b1;
    test_reset();
    test_write_read();
    test_invalid();
    test_misaligned();
    test_back_to_back();
    test_reset_priority();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_file_core.md
Name: reg_file_core

Overview:
- Small memory-mapped register file of NUM_REGS word registers, each DATA_W bits wide, at word-aligned byte addresses 0x00, 0x04, 0x08, 0x0C, … .
- Writes are synchronous; reads are combinational.
- Invalid addresses are write-ignored and read as zero.
- Sits behind a simple bus/control front-end as the block's configuration/status storage.

Parameters:
- NUM_REGS, 4: number of registers. Valid byte addresses are 0 … 4*(NUM_REGS-1), step 4.
- DATA_W, 32: register and data-bus width in bits.
- ADDR_W, 8: byte-address width. Must satisfy 4*NUM_REGS <= 2**ADDR_W.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- we  input  1  write enable.
- re  input  1  read enable.
- addr  input  ADDR_W  byte address, shared by read and write.
- wdata  input  DATA_W  write data.
- rdata  output  DATA_W  read data, combinational.

Interface: one clock (clk); reset rst_n is synchronous and active-low.

Behaviour:
- Address decode:
  - valid = (addr[1:0] == 0) && (addr[ADDR_W-1:2] < NUM_REGS).
  - index = addr[ADDR_W-1:2].
  - Misaligned or out-of-range addresses (e.g. 0x10, 0x02 with defaults) are invalid.
- Reset:
  - On a rising clk edge with rst_n=0, all registers become 0.
  - Reset has priority over a same-cycle write, which is dropped.
  - Reset mid-sequence clears contents immediately at that edge; no other state exists.
- Write:
  - On a rising clk edge with rst_n=1, we=1 and valid address, reg[index] <= wdata.
  - Invalid-address writes change nothing.
  - Write latency is 1 cycle: the new value is visible on rdata the cycle after the write edge.
- Read:
  - rdata = (re && valid) ? reg[index] : 0.
  - Purely combinational, zero-cycle latency; no read side effects.
- Simultaneous we=1 and re=1 at the same valid address: rdata shows the old value until the edge, then the new value (no write-through bypass).
- rdata is 0 while re=0, for invalid addresses, and after reset until a register is written.
- No handshake or stall: every request completes in its cycle.

Optional Feature:
- Macro: REG_FILE_ERR_EN.
- When defined:
  - Adds output port err (1 bit, combinational).
  - err = (we || re) && !valid.
  - Additionally adds registered output err_sticky (1 bit). It sets on any rising edge where err=1, clears only on reset, and resets to 0.
- When undefined: neither port exists; invalid accesses are silently ignored as above.

Test Plan:
- Hold rst_n=0 for 2 edges, release. Read 0x00, 0x04, 0x08, 0x0C with re=1 -> rdata=0x00000000 each.
- Write 0xDEADBEEF to 0x00, then read 0x00 -> rdata=0xDEADBEEF. Write 0x12345678 to 0x0C, read 0x0C -> 0x12345678; 0x04 still reads 0.
- Write 0xAAAAAAAA to 0x10 (invalid) -> read 0x10 gives 0, 0x00 still 0xDEADBEEF, all registers unchanged. With REG_FILE_ERR_EN: err=1 during the access, err_sticky=1 afterwards.
- Misaligned write 0x55555555 to 0x06 -> ignored; 0x04 and 0x08 unchanged.
- we=1 and re=1 at 0x08 with wdata=0xCAFEF00D -> rdata is the old value in the write cycle, 0xCAFEF00D next cycle. With re=0 and addr=0x08 -> rdata=0.
- Assert rst_n=0 together with we=1 (addr 0x04, data 0x1) -> all registers read 0 after the edge; the write is dropped; err_sticky cleared.
